// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared FSM encoding, data width and sizing helper for mult_arbiter
package mult_arb_pkg;
   localparam int MULT_DW   = 8;
   localparam int N_REQ_DEF = 4;
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LAUNCH   = 3'd1,
      WAIT_ACK = 3'd2,
      RUN      = 3'd3,
      DONE     = 3'd4
   } state_t;
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// rr_pick: combinational round-robin one-hot picker starting the search at ptr
module rr_pick
   import mult_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int PW    = ptr_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [N_REQ-1:0] onehot,
   output logic [PW-1:0]    idx
);
   int c;
   // scan from farthest to nearest so the requester closest to ptr wins
   always_comb begin
      onehot = '0;
      idx    = '0;
      c      = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         c = (int'(ptr) + k) % N_REQ;
         if (req[c]) begin
            onehot = N_REQ'(1) << c;
            idx    = c[PW-1:0];
         end
      end
   end
endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sequencer sharing one mult unit; watchdog enabled by MULT_ARB_TIMEOUT_EN
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int N_REQ       = N_REQ_DEF,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req,
   input  logic [MULT_DW*N_REQ-1:0] req_sw_in,
   input  logic [MULT_DW*N_REQ-1:0] req_seq_num,
   output logic [N_REQ-1:0]         grant,
   output logic [N_REQ-1:0]         rsp_valid,
   output logic [MULT_DW-1:0]       rsp_num,
   output logic                     err,
   output logic                     m_start,
   output logic [MULT_DW-1:0]       m_sw_in,
   output logic [MULT_DW-1:0]       m_seq_num,
   input  logic [MULT_DW-1:0]       m_num,
   input  logic                     m_busy
);
   localparam int PW = ptr_w(N_REQ);
   state_t            state, state_n;
   logic [PW-1:0]     ptr, win, pick_idx;
   logic [N_REQ-1:0]  pick_oh;
   logic              launch, tmo, to_hit;
   rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
      .req    (req),
      .ptr    (ptr),
      .onehot (pick_oh),
      .idx    (pick_idx)
   );
   // a unit still busy from before our reset blocks new launches
   assign launch    = (state == IDLE) && (|req) && !m_busy;
   assign m_start   = (state == LAUNCH);
   assign rsp_valid = (state == DONE) ? grant : '0;
`ifdef MULT_ARB_TIMEOUT_EN
   logic [7:0] wd;
   logic       to_flag;
   assign tmo    = ((state == WAIT_ACK) || (state == RUN)) && (wd == 8'(TIMEOUT_CYC - 1));
   assign to_hit = tmo && ((state == WAIT_ACK) ? !m_busy : m_busy);
   assign err    = (state == DONE) && to_flag;
   // watchdog counts cycles in the waiting states, restarting on every state change
   always_ff @(posedge clk) begin
      if (reset || (state_n != state)) wd <= '0;
      else if ((state == WAIT_ACK) || (state == RUN)) wd <= wd + 8'd1;
      to_flag <= reset ? 1'b0 : to_hit;
   end
`else
   assign tmo    = 1'b0;
   assign to_hit = 1'b0;
   assign err    = 1'b0;
`endif
   // state register
   always_ff @(posedge clk) begin
      state <= reset ? IDLE : state_n;
   end
   // next-state logic
   always_comb begin
      state_n = state;
      case (state)
         IDLE:     state_n = launch ? LAUNCH : IDLE;
         LAUNCH:   state_n = WAIT_ACK;
         WAIT_ACK: state_n = m_busy ? RUN : (tmo ? DONE : WAIT_ACK);
         RUN:      state_n = (!m_busy || tmo) ? DONE : RUN;
         DONE:     state_n = IDLE;
         default:  state_n = IDLE;
      endcase
   end
   // grant, operand latches, result capture and pointer advance
   always_ff @(posedge clk) begin
      if (reset) begin
         grant     <= '0;
         win       <= '0;
         ptr       <= '0;
         m_sw_in   <= '0;
         m_seq_num <= '0;
         rsp_num   <= '0;
      end else begin
         if (launch) begin
            grant     <= pick_oh;
            win       <= pick_idx;
            m_sw_in   <= req_sw_in[MULT_DW*int'(pick_idx) +: MULT_DW];
            m_seq_num <= req_seq_num[MULT_DW*int'(pick_idx) +: MULT_DW];
         end
         if ((state_n == DONE) && (state != DONE)) rsp_num <= to_hit ? '0 : m_num;
         if (state == DONE) begin
            grant <= '0;
            ptr   <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
         end
      end
   end
endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Sequencer and round-robin arbiter that shares one `mult` pseudo-random generator among `N_REQ` requesters. It latches the winning requester's `sw_in`/`seq_num` operands, pulses `start`, and tracks the unit's `busy` through to completion. It then returns the 8-bit `num` result to the winning requester with a one-cycle valid strobe. It sits between the switch/sequence front-end logic and the single `mult` instance.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `TIMEOUT_CYC`, default 255: watchdog limit in cycles; used only when `MULT_ARB_TIMEOUT_EN` is defined.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in N_REQ: per-requester request level.
- `req_sw_in` in 8*N_REQ: operand A; requester i occupies bits [8i+7:8i].
- `req_seq_num` in 8*N_REQ: operand B, packed the same way.
- `grant` out N_REQ: one-hot; high from LAUNCH through DONE.
- `rsp_valid` out N_REQ: one-hot, one-cycle result strobe.
- `rsp_num` out 8: result; holds its value until the next DONE.
- `err` out 1: one-cycle timeout strobe.
- `m_start` out 1: one-cycle start pulse to `mult`.
- `m_sw_in`, `m_seq_num` out 8 each: latched operands, held stable during an operation.
- `m_num` in 8: `mult` result.
- `m_busy` in 1: `mult` busy.

## Operation
- **FSM states:** IDLE, LAUNCH, WAIT_ACK, RUN, DONE.
- **IDLE:** if any `req` bit is set and `m_busy`==0, pick the winner with rr_pick, starting from pointer `ptr`. Latch that requester's operands into `m_sw_in`/`m_seq_num`, set `grant`, then go to LAUNCH.
- **IDLE with `m_busy`==1:** stay in IDLE. This covers a `mult` that is still running after this block was reset.
- **LAUNCH:** `m_start`=1 for exactly this cycle, then go to WAIT_ACK.
- **WAIT_ACK:** stay until `m_busy`==1, then go to RUN.
- **RUN:** stay until `m_busy`==0, then go to DONE.
- **DONE:** `rsp_num`<=`m_num`, `rsp_valid`=`grant` for this cycle, `grant`<=0, `ptr`<=winner+1 mod N_REQ, then go to IDLE.
- **Requester protocol:** hold `req` and operands until its `rsp_valid` is seen. Operands are latched in IDLE, so later changes are ignored.
- **`req` dropped mid-operation:** the operation still completes and `rsp_valid` is still issued.
- **`req` still high at the `rsp_valid` cycle:** counts as a new request. Because `ptr` has advanced, it has the lowest priority among active requesters.
- **Round-robin:** a continuously requesting requester waits at most N_REQ-1 operations.
- **Reset:** at any point, including mid-operation, all outputs are 0, `ptr`=0 and the state is IDLE. The in-flight result is discarded and no `rsp_valid` is issued.

## Timing
- Request sampled in IDLE at edge 0 → `grant` and `m_start` visible in cycle 1.
- `rsp_valid` comes 1 cycle after the edge where `m_busy` is first seen low in RUN.
- Minimum turnaround (`m_busy` rises in cycle 2, falls in cycle 2+B): `rsp_valid` in cycle 3+B.
- Back-to-back: the next LAUNCH is no earlier than 2 cycles after DONE (DONE→IDLE→LAUNCH).
- `m_start` never asserts while `m_busy`==1 is sampled in IDLE.

## Configuration
- **`MULT_ARB_TIMEOUT_EN` defined:** an 8-bit watchdog counts cycles in WAIT_ACK and RUN, clearing on each state entry. On reaching TIMEOUT_CYC:
  - `err`=1 for one cycle.
  - `rsp_valid` is issued for the winner with `rsp_num`=8'h00.
  - `grant`<=0, `ptr` advances, and the FSM returns to IDLE.
- **Not defined:** no counter is built, `err` is tied to 0, and WAIT_ACK/RUN wait indefinitely.

## Structure
- **Package `mult_arb_pkg`:** state encoding (IDLE=0..DONE=4), data width constant `MULT_DW`=8, default `N_REQ`.
- **Sub-module `rr_pick`:** combinational round-robin one-hot picker, inputs (`req`, `ptr`), outputs (`onehot`, `idx`).
- The FSM, operand latches and watchdog stay in `mult_arbiter`.

## Test plan
- **Single request:** `req`=4'b0001, operands 8'h08/8'h09, model `busy` high for 5 cycles → one `m_start` pulse, `m_sw_in`=8'h08, `m_seq_num`=8'h09, `rsp_valid`=4'b0001, `rsp_num`=model result.
- **Fairness:** all four requesters held high → grant order 0,1,2,3,0.
- **Early drop:** requester 2 drops `req` after LAUNCH → `rsp_valid`=4'b0100 still issued and `ptr`=3.
- **Reset mid-run:** `reset` asserted in RUN → next cycle all outputs are 0; with `m_busy` still high, no `m_start` until `m_busy` falls.
- **Watchdog:** with `MULT_ARB_TIMEOUT_EN` and TIMEOUT_CYC=16, model never raises `busy` → `err` pulse after 16 cycles in WAIT_ACK, `rsp_num`=8'h00.
- **Operand change after latch:** requester changes `req_sw_in` to 8'hFF after LAUNCH → `m_sw_in` stays 8'h08 until DONE.
